// File: rtl/operand_collector.sv
// Four-entry operand collector: allocates issued instructions, reads sources over one RF port,
// raises ALU/MEM requests and dispatches registered bundles. Optional: OC_SAME_SRC_MERGE_EN.
module operand_collector #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned WARP_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Valid_IB_OC,
  output logic                          Ready_OC_IB,
  input  logic [WARP_W+34:0]            Instr_IB_OC,
  output logic                          RF_Req_OC_RF,
  output logic [WARP_W+4:0]             RF_Addr_OC_RF,
  input  logic [DATA_W-1:0]             RF_Data_RF_OC,
  output logic [3:0]                    ALU_Req_OC_Sched,
  output logic [3:0]                    MEM_Req_OC_Sched,
  output logic [3:0]                    ALU_RegWrite_OC_Sched,
  input  logic [3:0]                    ALU_Grt_Sched_OC,
  input  logic [3:0]                    MEM_Grt_Sched_OC,
  output logic                          ALU_Valid_OC_ALU,
  output logic [WARP_W+21+2*DATA_W:0]   ALU_Bundle_OC_ALU,
  output logic                          MEM_Valid_OC_MEM,
  output logic [WARP_W+21+2*DATA_W:0]   MEM_Bundle_OC_MEM
);
  localparam int unsigned BW = WARP_W + 22 + 2 * DATA_W;

  typedef enum logic [1:0] {StEmpty, StCollect, StReady} state_e;

  state_e              r_state [4];
  logic [WARP_W-1:0]   r_warp  [4];
  logic [4:0]          r_src1  [4];
  logic [4:0]          r_src2  [4];
  logic [4:0]          r_dst   [4];
  logic [15:0]         r_imm   [4];
  logic [DATA_W-1:0]   r_d1    [4];
  logic [DATA_W-1:0]   r_d2    [4];
  logic [3:0]          r_pend1, r_pend2, r_regwr, r_memop;
  logic                r_tag_vld, r_tag_slot;
  logic [1:0]          r_tag_ent, r_rr;
  logic                r_alu_vld, r_mem_vld;
  logic [BW-1:0]       r_alu_bundle, r_mem_bundle;

  logic [3:0]          w_ret1, w_ret2, w_rd1, w_rd2, w_alu_req, w_mem_req;
  logic                w_alloc_found, w_rf_found, w_rf_slot, w_alu_found, w_mem_found;
  logic [1:0]          w_alloc_idx, w_rf_idx, w_cand, w_alu_idx, w_mem_idx;
  logic [BW-1:0]       w_alu_payload, w_mem_payload;
  logic                w_alloc;
  logic [3:0]          w_alu_hit, w_mem_hit;

  wire  [WARP_W-1:0]   w_i_warp = Instr_IB_OC[WARP_W+34:35];
  wire  [4:0]          w_i_src1 = Instr_IB_OC[34:30];
  wire                 w_i_use1 = Instr_IB_OC[29];
  wire  [4:0]          w_i_src2 = Instr_IB_OC[28:24];
  wire                 w_i_use2 = Instr_IB_OC[23];

`ifdef OC_SAME_SRC_MERGE_EN
  logic [3:0] r_dup;
  wire        w_merge = w_i_use1 && w_i_use2 && (w_i_src1 == w_i_src2);
`else
  wire        w_merge = 1'b0;
`endif

  // Operand eligibility; a slot whose data returns this cycle no longer blocks the next read.
  always_comb begin
    w_ret1 = '0;
    w_ret2 = '0;
    w_rd1  = '0;
    w_rd2  = '0;
    w_alu_req = '0;
    w_mem_req = '0;
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      w_ret1[i] = r_tag_vld && (r_tag_ent == 2'(i)) && !r_tag_slot;
      w_ret2[i] = r_tag_vld && (r_tag_ent == 2'(i)) && r_tag_slot;
      w_rd1[i]  = (r_state[i] == StCollect) && r_pend1[i] && !w_ret1[i];
      w_rd2[i]  = (r_state[i] == StCollect) && r_pend2[i] && !w_ret2[i] &&
                  (!r_pend1[i] || w_ret1[i]);
      w_alu_req[i] = (r_state[i] == StReady) && !r_memop[i];
      w_mem_req[i] = (r_state[i] == StReady) && r_memop[i];
      if (r_state[i] == StEmpty) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    w_rf_found = 1'b0;
    w_rf_idx   = '0;
    w_cand     = '0;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_rr + 2'(k);
      if (!w_rf_found && (w_rd1[w_cand] || w_rd2[w_cand])) begin
        w_rf_found = 1'b1;
        w_rf_idx   = w_cand;
      end
    end
    w_rf_slot = !w_rd1[w_rf_idx];
  end

  // Only the lowest requesting bit of each grant vector is honoured.
  always_comb begin
    w_alu_hit   = ALU_Grt_Sched_OC & w_alu_req;
    w_mem_hit   = MEM_Grt_Sched_OC & w_mem_req;
    w_alu_found = 1'b0;
    w_mem_found = 1'b0;
    w_alu_idx   = '0;
    w_mem_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_alu_hit[i]) begin
        w_alu_found = 1'b1;
        w_alu_idx   = 2'(i);
      end
      if (w_mem_hit[i]) begin
        w_mem_found = 1'b1;
        w_mem_idx   = 2'(i);
      end
    end
    w_alu_payload = {r_warp[w_alu_idx], r_dst[w_alu_idx], r_regwr[w_alu_idx], r_imm[w_alu_idx],
                     r_d2[w_alu_idx], r_d1[w_alu_idx]};
    w_mem_payload = {r_warp[w_mem_idx], r_dst[w_mem_idx], r_regwr[w_mem_idx], r_imm[w_mem_idx],
                     r_d2[w_mem_idx], r_d1[w_mem_idx]};
  end

  assign w_alloc               = Valid_IB_OC && w_alloc_found;
  assign Ready_OC_IB           = w_alloc_found;
  assign RF_Req_OC_RF          = w_rf_found;
  assign RF_Addr_OC_RF         = w_rf_found ?
      {r_warp[w_rf_idx], (w_rf_slot ? r_src2[w_rf_idx] : r_src1[w_rf_idx])} : '0;
  assign ALU_Req_OC_Sched      = w_alu_req;
  assign MEM_Req_OC_Sched      = w_mem_req;
  assign ALU_RegWrite_OC_Sched = w_alu_req & r_regwr;
  assign ALU_Valid_OC_ALU      = r_alu_vld;
  assign ALU_Bundle_OC_ALU     = r_alu_bundle;
  assign MEM_Valid_OC_MEM      = r_mem_vld;
  assign MEM_Bundle_OC_MEM     = r_mem_bundle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= StEmpty;
        r_warp[i]  <= '0;
        r_src1[i]  <= '0;
        r_src2[i]  <= '0;
        r_dst[i]   <= '0;
        r_imm[i]   <= '0;
        r_d1[i]    <= '0;
        r_d2[i]    <= '0;
      end
      r_pend1      <= '0;
      r_pend2      <= '0;
      r_regwr      <= '0;
      r_memop      <= '0;
`ifdef OC_SAME_SRC_MERGE_EN
      r_dup        <= '0;
`endif
      r_tag_vld    <= 1'b0;
      r_tag_slot   <= 1'b0;
      r_tag_ent    <= '0;
      r_rr         <= '0;
      r_alu_vld    <= 1'b0;
      r_mem_vld    <= 1'b0;
      r_alu_bundle <= '0;
      r_mem_bundle <= '0;
    end else begin
      r_tag_vld  <= w_rf_found;
      r_tag_ent  <= w_rf_idx;
      r_tag_slot <= w_rf_slot;
      if (w_rf_found) r_rr <= w_rf_idx + 2'd1;
      if (r_tag_vld) begin
        if (!r_tag_slot) begin
          r_d1[r_tag_ent]    <= RF_Data_RF_OC;
          r_pend1[r_tag_ent] <= 1'b0;
`ifdef OC_SAME_SRC_MERGE_EN
          if (r_dup[r_tag_ent]) r_d2[r_tag_ent] <= RF_Data_RF_OC;
`endif
        end else begin
          r_d2[r_tag_ent]    <= RF_Data_RF_OC;
          r_pend2[r_tag_ent] <= 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        unique case (r_state[i])
          StEmpty: begin
            if (w_alloc && (w_alloc_idx == 2'(i))) begin
              r_state[i] <= (w_i_use1 || w_i_use2) ? StCollect : StReady;
              r_warp[i]  <= w_i_warp;
              r_src1[i]  <= w_i_src1;
              r_src2[i]  <= w_i_src2;
              r_dst[i]   <= Instr_IB_OC[22:18];
              r_regwr[i] <= Instr_IB_OC[17];
              r_memop[i] <= Instr_IB_OC[16];
              r_imm[i]   <= Instr_IB_OC[15:0];
              r_pend1[i] <= w_i_use1;
              r_pend2[i] <= w_i_use2 && !w_merge;
              r_d1[i]    <= '0;
              r_d2[i]    <= '0;
`ifdef OC_SAME_SRC_MERGE_EN
              r_dup[i]   <= w_merge;
`endif
            end
          end
          StCollect: begin
            if (!(r_pend1[i] && !w_ret1[i]) && !(r_pend2[i] && !w_ret2[i])) begin
              r_state[i] <= StReady;
            end
          end
          StReady: begin
            if ((w_alu_found && (w_alu_idx == 2'(i))) || (w_mem_found && (w_mem_idx == 2'(i)))) begin
              r_state[i] <= StEmpty;
            end
          end
          default: r_state[i] <= StEmpty;
        endcase
      end
      r_alu_vld <= w_alu_found;
      r_mem_vld <= w_mem_found;
      if (w_alu_found) r_alu_bundle <= w_alu_payload;
      if (w_mem_found) r_mem_bundle <= w_mem_payload;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Directed self-checking bench for operand_collector with a one-cycle-latency RF model.
module tb_operand_collector;
  localparam int unsigned BW = 537;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [37:0]     instr;
  logic            rf_req;
  logic [7:0]      rf_addr;
  logic [255:0]    rf_data = '0;
  logic [3:0]      alu_req, mem_req, alu_rw;
  logic [3:0]      alu_drv, mem_drv, alu_grt;
  logic            tie;
  logic            alu_vld, mem_vld;
  logic [BW-1:0]   alu_bundle, mem_bundle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_grt = tie ? alu_req : alu_drv;

  operand_collector dut (
    .clk                  (clk),
    .rst                  (rst),
    .Valid_IB_OC          (valid),
    .Ready_OC_IB          (ready),
    .Instr_IB_OC          (instr),
    .RF_Req_OC_RF         (rf_req),
    .RF_Addr_OC_RF        (rf_addr),
    .RF_Data_RF_OC        (rf_data),
    .ALU_Req_OC_Sched     (alu_req),
    .MEM_Req_OC_Sched     (mem_req),
    .ALU_RegWrite_OC_Sched(alu_rw),
    .ALU_Grt_Sched_OC     (alu_grt),
    .MEM_Grt_Sched_OC     (mem_drv),
    .ALU_Valid_OC_ALU     (alu_vld),
    .ALU_Bundle_OC_ALU    (alu_bundle),
    .MEM_Valid_OC_MEM     (mem_vld),
    .MEM_Bundle_OC_MEM    (mem_bundle)
  );

  function automatic logic [255:0] rf_val(input logic [7:0] a);
    return {8{{24'hC0FFEE, a}}};
  endfunction

  // Register file: data for a request appears the following cycle.
  always @(posedge clk) rf_data <= rf_req ? rf_val(rf_addr) : '0;

  function automatic logic [37:0] mk(input logic [2:0] w, input logic [4:0] s1, input logic u1,
                                     input logic [4:0] s2, input logic u2, input logic [4:0] d,
                                     input logic rw, input logic mem, input logic [15:0] imm);
    return {w, s1, u1, s2, u2, d, rw, mem, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; instr = '0; alu_drv = '0; mem_drv = '0; tie = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_rfreq", rf_req, 0);
    chk("rst_reqs", {alu_req, mem_req, alu_rw}, 0);
    chk("rst_valids", {alu_vld, mem_vld}, 0);
    chk("rst_bundles", {alu_bundle[63:0], mem_bundle[63:0]}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", ready, 1);
    chk("post_rst_rfreq", rf_req, 0);

    // Single two-operand ALU instruction, grant tied to request.
    valid = 1'b1;
    instr = mk(3'd2, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 16'h1234);
    step();
    valid = 1'b0;
    chk("t1_rfreq_t1", rf_req, 1);
    chk("t1_addr_t1", rf_addr, 8'h43);
    step();
    chk("t1_rfreq_t2", rf_req, 1);
    chk("t1_addr_t2", rf_addr, 8'h44);
    step();
    chk("t1_idle_t3", {rf_req, alu_req}, 0);
    tie = 1'b1;
    step();
    chk("t1_alureq_t4", alu_req, 4'b0001);
    chk("t1_alurw_t4", alu_rw, 4'b0001);
    chk("t1_memreq_t4", mem_req, 0);
    step();
    tie = 1'b0;
    chk("t1_valid_t5", alu_vld, 1);
    chk("t1_bundle_t5", alu_bundle,
        {3'd2, 5'd9, 1'b1, 16'h1234, rf_val(8'h44), rf_val(8'h43)});
    chk("t1_empty_t5", {alu_req, ready}, 5'b00001);
    step();
    chk("t1_valid_pulse", alu_vld, 0);

    // Back-to-back operand-free instructions, fill and stall.
    valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = mk(3'(k + 1), 5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1, 1'b0, 16'h00A0 + 16'(k));
      step();
    end
    chk("t2_full_ready", ready, 0);
    chk("t2_full_req", alu_req, 4'b1111);
    instr = mk(3'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 16'h00B5);
    step();
    chk("t2_held_ready", ready, 0);
    chk("t2_held_memreq", mem_req, 0);
    chk("t2_held_alureq", alu_req, 4'b1111);
    alu_drv = 4'b0100;
    step();
    alu_drv = '0;
    chk("t2_free_valid", alu_vld, 1);
    chk("t2_free_warp", alu_bundle[BW-1:BW-3], 3'd3);
    chk("t2_free_ready", ready, 1);
    chk("t2_free_alureq", alu_req, 4'b1011);
    step();
    valid = 1'b0;
    chk("t2_realloc_mem", mem_req, 4'b0100);
    chk("t2_realloc_ready", ready, 0);
    chk("t2_realloc_vld", alu_vld, 0);
    alu_drv = 4'b1011;
    step();
    alu_drv = '0;
    chk("t2_multi_valid", alu_vld, 1);
    chk("t2_multi_warp", alu_bundle[BW-1:BW-3], 3'd1);
    chk("t2_multi_req", alu_req, 4'b1010);
    alu_drv = 4'b0010;
    mem_drv = 4'b0100;
    step();
    alu_drv = '0;
    mem_drv = '0;
    chk("t2_dual_valids", {alu_vld, mem_vld}, 2'b11);
    chk("t2_dual_alu_warp", alu_bundle[BW-1:BW-3], 3'd2);
    chk("t2_dual_mem_warp", mem_bundle[BW-1:BW-3], 3'd5);
    chk("t2_dual_reqs", {alu_req, mem_req}, 8'b1000_0000);
    alu_drv = 4'b1000;
    step();
    alu_drv = '0;
    chk("t2_drained", {alu_req, ready}, 5'b00001);

    // Four entries collecting: round-robin reads, spurious grant, reset mid-collect.
    valid = 1'b1;
    instr = mk(3'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0);
    step();
    instr = mk(3'd1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0);
    chk("t3_rr0", rf_addr, 8'h01);
    step();
    instr = mk(3'd2, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0);
    chk("t3_rr1", rf_addr, 8'h21);
    step();
    instr = mk(3'd3, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 16'h0);
    alu_drv = 4'b0100;
    chk("t3_rr2", rf_addr, 8'h41);
    step();
    valid = 1'b0;
    alu_drv = '0;
    chk("t3_rr3", rf_addr, 8'h61);
    chk("t3_spurious_vld", alu_vld, 0);
    chk("t3_full", ready, 0);
    step();
    chk("t3_rr4", rf_addr, 8'h02);
    step();
    chk("t3_rr5", rf_addr, 8'h22);
    step();
    chk("t3_rr6", rf_addr, 8'h42);
    chk("t3_first_ready", alu_req, 4'b0001);
    rst = 1'b1;
    #1;
    chk("t3_rst_rfreq", rf_req, 0);
    chk("t3_rst_req", alu_req, 0);
    chk("t3_rst_ready", ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("t3_post_rfreq", rf_req, 0);
    chk("t3_post_state", {alu_req, mem_req, alu_vld}, 0);

    // Same source register on both slots.
    valid = 1'b1;
    instr = mk(3'd6, 5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 16'h00C7);
    step();
    valid = 1'b0;
    chk("t4_addr_t1", {rf_req, rf_addr}, {1'b1, 8'hC7});
    step();
`ifdef OC_SAME_SRC_MERGE_EN
    chk("t4_rfreq_t2", rf_req, 0);
`else
    chk("t4_addr_t2", {rf_req, rf_addr}, {1'b1, 8'hC7});
`endif
    step();
`ifdef OC_SAME_SRC_MERGE_EN
    chk("t4_req_t3", alu_req, 4'b0001);
`else
    chk("t4_req_t3", alu_req, 4'b0000);
`endif
    step();
    chk("t4_req_t4", alu_req, 4'b0001);
    alu_drv = 4'b0001;
    step();
    alu_drv = '0;
    chk("t4_valid", alu_vld, 1);
    chk("t4_bundle", alu_bundle,
        {3'd6, 5'd3, 1'b1, 16'h00C7, rf_val(8'hC7), rf_val(8'hC7)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
